// File: rtl/matmul_result_writeback.sv
// Matmul result write-back buffer: a small circular FIFO between the matmul unit and the VRF write port.
// It optionally clamps each lane to 32-bit signed on entry, checks for RAW hazards and keeps sticky status flags.
module matmul_result_writeback #(
    parameter int VLEN  = 256,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     res_valid_i,
    input  logic [4:0]               res_addr_i,
    input  logic [VLEN-1:0]          res_data_i,
    output logic                     res_ready_o,
    input  logic                     sat_mode_i,
    output logic                     vrf_we_o,
    output logic [4:0]               vrf_waddr_o,
    output logic [VLEN-1:0]          vrf_wdata_o,
    input  logic                     vrf_wgnt_i,
    input  logic [4:0]               chk_addr_a_i,
    input  logic [4:0]               chk_addr_b_i,
    output logic                     hazard_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o,
    output logic                     sat_o,
    input  logic                     clear_flags_i
);

    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = PW + 1;
    localparam int LANES = 4;

    localparam logic [CW-1:0]        FULL_CNT = CW'(DEPTH);
    localparam logic signed [63:0]   S32_MAX  = 64'sh0000_0000_7FFF_FFFF;
    localparam logic signed [63:0]   S32_MIN  = 64'shFFFF_FFFF_8000_0000;

    function automatic logic lane_clamps(input logic signed [63:0] x);
        return (x > S32_MAX) || (x < S32_MIN);
    endfunction

    function automatic logic [31:0] sat32(input logic signed [63:0] x);
        logic [31:0] r;
        if (x > S32_MAX) begin
            r = 32'h7FFF_FFFF;
        end else if (x < S32_MIN) begin
            r = 32'h8000_0000;
        end else begin
            r = x[31:0];
        end
        return r;
    endfunction

    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;
    logic            sat_q, sat_d;

    logic [4:0]      addr_mem [DEPTH];
    logic [VLEN-1:0] data_mem [DEPTH];

    logic            push_w;
    logic            pop_w;
    logic [VLEN-1:0] conv_data;
    logic            clamp_any;
    logic [DEPTH-1:0] occ;

    // ---- push-side conversion (combinational, sampled on the push edge) ----
    always_comb begin
        conv_data = res_data_i;
        clamp_any = 1'b0;
        if (sat_mode_i) begin
            conv_data = '0;
            for (int i = 0; i < LANES; i++) begin
                conv_data[i*32 +: 32] = sat32(res_data_i[i*64 +: 64]);
                clamp_any = clamp_any | lane_clamps(res_data_i[i*64 +: 64]);
            end
        end
    end

    // Ready depends only on the registered count, so the grant never reaches it.
    assign res_ready_o = (count_q != FULL_CNT);
    assign vrf_we_o    = (count_q != '0);
    assign push_w      = res_valid_i && res_ready_o;
    assign pop_w       = vrf_we_o && vrf_wgnt_i;

    always_comb begin
        wr_ptr_d = push_w ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop_w  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        unique case ({push_w, pop_w})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (res_valid_i && !res_ready_o) begin
            ovf_d = 1'b1;
        end else if (clear_flags_i) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
        if (push_w && clamp_any) begin
            sat_d = 1'b1;
        end else if (clear_flags_i) begin
            sat_d = 1'b0;
        end else begin
            sat_d = sat_q;
        end
    end

    // ---- control state ----
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            sat_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            sat_q    <= sat_d;
        end
    end

    // ---- entry storage (data path, not reset; validity comes from count/pointers) ----
    always_ff @(posedge clk_i) begin
        if (push_w) begin
            addr_mem[wr_ptr_q] <= res_addr_i;
            data_mem[wr_ptr_q] <= conv_data;
        end
    end

    // An entry is occupied when its distance from the read pointer is below the count.
    always_comb begin
        occ      = '0;
        hazard_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            occ[i] = ({1'b0, PW'(i) - rd_ptr_q} < count_q);
            if (occ[i] && ((addr_mem[i] == chk_addr_a_i) || (addr_mem[i] == chk_addr_b_i))) begin
                hazard_o = 1'b1;
            end
        end
    end

    assign vrf_waddr_o = vrf_we_o ? addr_mem[rd_ptr_q] : 5'd0;
    assign vrf_wdata_o = vrf_we_o ? data_mem[rd_ptr_q] : '0;
    assign count_o     = count_q;
    assign overflow_o  = ovf_q;
    assign sat_o       = sat_q;

endmodule

// File: tb/tb_matmul_result_writeback.sv
// Scoreboard bench for matmul_result_writeback: a queue-based model predicts occupancy, flags and hazards,
// and a separate monitor pops expected writes whenever the DUT's VRF write is granted.
module tb_matmul_result_writeback;

    localparam int VLEN  = 256;
    localparam int DEPTH = 4;
    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              res_valid_i;
    logic [4:0]        res_addr_i;
    logic [VLEN-1:0]   res_data_i;
    logic              res_ready_o;
    logic              sat_mode_i;
    logic              vrf_we_o;
    logic [4:0]        vrf_waddr_o;
    logic [VLEN-1:0]   vrf_wdata_o;
    logic              vrf_wgnt_i;
    logic [4:0]        chk_addr_a_i;
    logic [4:0]        chk_addr_b_i;
    logic              hazard_o;
    logic [2:0]        count_o;
    logic              overflow_o;
    logic              sat_o;
    logic              clear_flags_i;

    matmul_result_writeback #(.VLEN(VLEN), .DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .res_valid_i(res_valid_i), .res_addr_i(res_addr_i), .res_data_i(res_data_i),
        .res_ready_o(res_ready_o), .sat_mode_i(sat_mode_i),
        .vrf_we_o(vrf_we_o), .vrf_waddr_o(vrf_waddr_o), .vrf_wdata_o(vrf_wdata_o),
        .vrf_wgnt_i(vrf_wgnt_i), .chk_addr_a_i(chk_addr_a_i), .chk_addr_b_i(chk_addr_b_i),
        .hazard_o(hazard_o), .count_o(count_o), .overflow_o(overflow_o), .sat_o(sat_o),
        .clear_flags_i(clear_flags_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [4:0]      a;
        logic [VLEN-1:0] d;
    } ent_t;

    ent_t mdl[$];
    ent_t exp_q[$];
    bit   ov_m;
    bit   sat_m;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [VLEN-1:0] mk(input longint l0, input longint l1, input longint l2, input longint l3);
        return {l3, l2, l1, l0};
    endfunction

    // Expected stored image: raw copy, or each signed lane clamped into 32 bits with the top half zero.
    task automatic convert(input logic [VLEN-1:0] d, input bit s, output logic [VLEN-1:0] o, output bit c);
        longint v;
        o = d;
        c = 1'b0;
        if (s) begin
            o = '0;
            for (int i = 0; i < 4; i++) begin
                v = d[i*64 +: 64];
                if (v > MAXV) begin
                    o[i*32 +: 32] = 32'h7FFF_FFFF;
                    c = 1'b1;
                end else if (v < MINV) begin
                    o[i*32 +: 32] = 32'h8000_0000;
                    c = 1'b1;
                end else begin
                    o[i*32 +: 32] = v[31:0];
                end
            end
        end
    endtask

    function automatic logic [63:0] rnd_lane();
        case ($urandom_range(0, 4))
            0:       return longint'($urandom_range(0, 2000)) - 64'sd1000;
            1:       return {$urandom, $urandom};
            2:       return MAXV + longint'($urandom_range(0, 2)) - 64'sd1;
            3:       return MINV - longint'($urandom_range(0, 2)) + 64'sd1;
            default: return longint'($signed($urandom));
        endcase
    endfunction

    function automatic logic [VLEN-1:0] rnd_data();
        logic [VLEN-1:0] d;
        for (int i = 0; i < 4; i++) d[i*64 +: 64] = rnd_lane();
        return d;
    endfunction

    task automatic check_state();
        bit hz;
        hz = 1'b0;
        foreach (mdl[k]) if (mdl[k].a == chk_addr_a_i || mdl[k].a == chk_addr_b_i) hz = 1'b1;
        chk("count", count_o, mdl.size());
        chk("ready", res_ready_o, mdl.size() != DEPTH);
        chk("we", vrf_we_o, mdl.size() != 0);
        if (mdl.size() != 0) begin
            chk("head_addr", vrf_waddr_o, mdl[0].a);
            chk("head_data", vrf_wdata_o, mdl[0].d);
        end else begin
            chk("idle_addr", vrf_waddr_o, 0);
            chk("idle_data", vrf_wdata_o, 0);
        end
        chk("hazard", hazard_o, hz);
        chk("overflow", overflow_o, ov_m);
        chk("sat", sat_o, sat_m);
    endtask

    // One clock cycle: drive, check the pre-edge state at the falling edge, advance the model.
    task automatic step(input bit v, input logic [4:0] a, input logic [VLEN-1:0] d, input bit s,
                        input bit g, input logic [4:0] ca, input logic [4:0] cb, input bit clr);
        logic [VLEN-1:0] cd;
        bit              c;
        bit              full;
        ent_t            e;
        res_valid_i   = v;
        res_addr_i    = a;
        res_data_i    = d;
        sat_mode_i    = s;
        vrf_wgnt_i    = g;
        chk_addr_a_i  = ca;
        chk_addr_b_i  = cb;
        clear_flags_i = clr;
        @(negedge clk_i);
        check_state();
        convert(d, s, cd, c);
        full = (mdl.size() == DEPTH);
        if (v && full) ov_m = 1'b1;
        else if (clr) ov_m = 1'b0;
        if (v && !full && c) sat_m = 1'b1;
        else if (clr) sat_m = 1'b0;
        if (g && mdl.size() != 0) void'(mdl.pop_front());
        if (v && !full) begin
            e.a = a;
            e.d = cd;
            mdl.push_back(e);
            exp_q.push_back(e);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input bit g);
        step(1'b0, 5'd0, '0, 1'b0, g, 5'd0, 5'd0, 1'b0);
    endtask

    // Monitor: every granted write must match the oldest accepted result.
    always @(negedge clk_i) begin
        if (!rst_i && vrf_we_o && vrf_wgnt_i) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_write: got addr %0d expected no write", vrf_waddr_o);
            end else begin
                ent_t e;
                e = exp_q.pop_front();
                chk("wr_addr", vrf_waddr_o, e.a);
                chk("wr_data", vrf_wdata_o, e.d);
            end
        end
    end

    initial begin
        rst_i = 1'b1;
        res_valid_i = 1'b0; res_addr_i = '0; res_data_i = '0; sat_mode_i = 1'b0;
        vrf_wgnt_i = 1'b0; chk_addr_a_i = '0; chk_addr_b_i = '0; clear_flags_i = 1'b0;
        ov_m = 1'b0; sat_m = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check_state();
        rst_i = 1'b0;

        // raw passthrough, one-cycle latency
        step(1'b1, 5'd17, mk(5, 6, 7, 8), 1'b0, 1'b1, 5'd0, 5'd0, 1'b0);
        chk("pass_we", vrf_we_o, 1);
        chk("pass_addr", vrf_waddr_o, 17);
        chk("pass_data", vrf_wdata_o, mk(5, 6, 7, 8));
        idle(1'b1);
        chk("pass_drained", count_o, 0);
        idle(1'b1);

        // saturation of each lane
        step(1'b1, 5'd3, mk(64'h1_0000_0000, -5, 64'hFFFF_FFFF_0000_0000, 3), 1'b1, 1'b0, 5'd0, 5'd0, 1'b0);
        chk("sat_data", vrf_wdata_o, {128'h0, 32'h0000_0003, 32'h8000_0000, 32'hFFFF_FFFB, 32'h7FFF_FFFF});
        chk("sat_flag", sat_o, 1);
        step(1'b1, 5'd4, mk(1, 2, 3, 4), 1'b1, 1'b1, 5'd0, 5'd0, 1'b1);
        chk("sat_cleared", sat_o, 0);
        step(1'b1, 5'd5, mk(0, MINV - 1, 0, 0), 1'b1, 1'b1, 5'd0, 5'd0, 1'b1);
        chk("sat_set_wins", sat_o, 1);
        idle(1'b1);
        idle(1'b1);
        step(1'b0, 5'd0, '0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b1);

        // fill, overflow, in-order drain
        for (int k = 0; k < 5; k++) step(1'b1, 5'(17 + k), rnd_data(), 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
        chk("full_count", count_o, 4);
        chk("full_ready", res_ready_o, 0);
        chk("full_ovf", overflow_o, 1);
        for (int k = 0; k < 4; k++) idle(1'b1);
        chk("full_drained", count_o, 0);
        step(1'b0, 5'd0, '0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b1);

        // RAW hazard tracking
        step(1'b1, 5'd18, rnd_data(), 1'b0, 1'b0, 5'd20, 5'd0, 1'b0);
        step(1'b1, 5'd20, rnd_data(), 1'b0, 1'b0, 5'd20, 5'd0, 1'b0);
        chk("haz_hit", hazard_o, 1);
        step(1'b0, 5'd0, '0, 1'b0, 1'b1, 5'd20, 5'd0, 1'b0);
        chk("haz_still", hazard_o, 1);
        step(1'b0, 5'd0, '0, 1'b0, 1'b1, 5'd20, 5'd0, 1'b0);
        chk("haz_gone", hazard_o, 0);
        step(1'b0, 5'd0, '0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b0);
        chk("haz_empty", hazard_o, 0);

        // same address twice, no coalescing
        step(1'b1, 5'd9, mk(1, 1, 1, 1), 1'b0, 1'b0, 5'd9, 5'd9, 1'b0);
        step(1'b1, 5'd9, mk(2, 2, 2, 2), 1'b0, 1'b0, 5'd9, 5'd9, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // steady push+pop at count 2 across three pointer laps
        step(1'b1, 5'd1, rnd_data(), 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
        step(1'b1, 5'd2, rnd_data(), 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
        for (int k = 0; k < 3 * DEPTH; k++)
            step(1'b1, 5'($urandom_range(0, 31)), rnd_data(), 1'($urandom_range(0, 1)), 1'b1,
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'b0);
        chk("lap_count", count_o, 2);
        idle(1'b1);
        idle(1'b1);

        // reset with entries pending
        for (int k = 0; k < 3; k++) step(1'b1, 5'(10 + k), rnd_data(), 1'b0, 1'b0, 5'd11, 5'd0, 1'b0);
        res_valid_i = 1'b0;
        rst_i = 1'b1;
        mdl.delete();
        exp_q.delete();
        ov_m = 1'b0;
        sat_m = 1'b0;
        #1;
        check_state();
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        for (int k = 0; k < 3; k++) idle(1'b1);

        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            logic [4:0] ca;
            ca = (mdl.size() != 0 && $urandom_range(0, 1) == 1) ? mdl[$urandom_range(0, mdl.size() - 1)].a
                                                                : 5'($urandom_range(0, 31));
            step($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), rnd_data(), 1'($urandom_range(0, 1)),
                 (k % 100 < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                 ca, 5'($urandom_range(0, 31)), $urandom_range(0, 15) == 0);
        end

        for (int k = 0; k < DEPTH + 1; k++) idle(1'b1);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
